// File: rtl/img_pkg.sv
// Shared pixel types, padding helpers and 3x3 kernel constants.
package img_pkg;

   typedef logic [7:0] pixel_t;

   localparam int unsigned MODE_GAUSS = 0;
   localparam int unsigned MODE_SOBEL = 1;

   // Gaussian kernel; the weighted sum is divided by 16.
   localparam int GAUSS_K [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
   localparam int GAUSS_SHIFT    = 4;

   // Sobel kernels, row 0 is the top window row.
   localparam int SOBEL_GX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
   localparam int SOBEL_GY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

   function automatic int unsigned padded_w(input int unsigned w);
      return w + 2;
   endfunction

   function automatic int unsigned padded_h(input int unsigned h);
      return h + 2;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One padded row of delay: dout is the sample written DEPTH enables ago.
module line_buffer
   import img_pkg::*;
#(
   parameter int unsigned DEPTH = 6
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   en,
   input  pixel_t din,
   output pixel_t dout
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   pixel_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_ptr;

   // Circular pointer, wraps at DEPTH-1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr <= '0;
      end else if (en) begin
         r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
      end
   end

   // Storage is not reset; stale contents are flushed before they are used.
   always_ff @(posedge clk) begin
      if (en) begin
         r_mem[r_ptr] <= din;
      end
   end

   assign dout = r_mem[r_ptr];

endmodule

// File: rtl/conv3x3.sv
// 3x3 sliding-window filter over a zero-padded raster stream.
module conv3x3
   import img_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned HEIGHT = 4,
   parameter int unsigned MODE   = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic [7:0] data_out,
   output logic       valid_out,
   input  logic       ready_in,
   output logic       last_out
);

   localparam int unsigned PW    = padded_w(WIDTH);
   localparam int unsigned PH    = padded_h(HEIGHT);
   localparam int unsigned COL_W = $clog2(PW);
   localparam int unsigned ROW_W = $clog2(PH);

   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   pixel_t            r_win [3][2];

   pixel_t            w_lb0;
   pixel_t            w_lb1;
   pixel_t            w_win [3][3];
   logic              w_accept;
   logic              w_emit;
   logic              w_col_end;
   logic              w_row_end;
   int                w_acc_g;
   int                w_acc_x;
   int                w_acc_y;
   logic signed [10:0] w_gx;
   logic signed [10:0] w_gy;
   logic [10:0]       w_ax;
   logic [10:0]       w_ay;
   logic [11:0]       w_ssum;
   pixel_t            w_gauss;
   pixel_t            w_sobel;
   pixel_t            w_filt;

   assign ready_out = !valid_out || ready_in;
   assign w_accept  = valid_in && ready_out;
   assign w_col_end = (r_col == COL_W'(PW - 1));
   assign w_row_end = (r_row == ROW_W'(PH - 1));
   assign w_emit    = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

   line_buffer #(.DEPTH(PW)) u_lb0 (
      .clk   (clk),
      .reset (reset),
      .en    (w_accept),
      .din   (data_in),
      .dout  (w_lb0)
   );

   line_buffer #(.DEPTH(PW)) u_lb1 (
      .clk   (clk),
      .reset (reset),
      .en    (w_accept),
      .din   (w_lb0),
      .dout  (w_lb1)
   );

   // Window as it looks after this accept: two stored columns plus the incoming column.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         w_win[r][0] = r_win[r][0];
         w_win[r][1] = r_win[r][1];
      end
      w_win[0][2] = w_lb1;
      w_win[1][2] = w_lb0;
      w_win[2][2] = data_in;
   end

   // Kernel accumulation for both filters.
   always_comb begin
      w_acc_g = 0;
      w_acc_x = 0;
      w_acc_y = 0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w_acc_g = w_acc_g + GAUSS_K[r][c]  * int'(32'(w_win[r][c]));
            w_acc_x = w_acc_x + SOBEL_GX[r][c] * int'(32'(w_win[r][c]));
            w_acc_y = w_acc_y + SOBEL_GY[r][c] * int'(32'(w_win[r][c]));
         end
      end
   end

   // Gaussian truncation and Sobel magnitude with saturation.
   always_comb begin
      w_gauss = 8'(w_acc_g >> GAUSS_SHIFT);
      w_gx    = 11'(w_acc_x);
      w_gy    = 11'(w_acc_y);
      w_ax    = w_gx[10] ? 11'(-w_gx) : 11'(w_gx);
      w_ay    = w_gy[10] ? 11'(-w_gy) : 11'(w_gy);
      w_ssum  = 12'(w_ax) + 12'(w_ay);
      w_sobel = (w_ssum > 12'd255) ? 8'hFF : w_ssum[7:0];
      w_filt  = (MODE == MODE_SOBEL) ? w_sobel : w_gauss;
   end

   // Padded-frame position of the next accepted pixel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   // Shift the window left by one column on every accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < 3; r++) begin
            r_win[r][0] <= '0;
            r_win[r][1] <= '0;
         end
      end else if (w_accept) begin
         for (int r = 0; r < 3; r++) begin
            r_win[r][0] <= r_win[r][1];
            r_win[r][1] <= w_win[r][2];
         end
      end
   end

   // Single output register; holds under backpressure.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out  <= '0;
         valid_out <= 1'b0;
         last_out  <= 1'b0;
      end else if (w_emit) begin
         data_out  <= w_filt;
         valid_out <= 1'b1;
         last_out  <= w_row_end && w_col_end;
      end else if (ready_in) begin
         valid_out <= 1'b0;
         last_out  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv3x3.sv
// Directed bench: Gaussian and Sobel instances share one stimulus stream.
module tb_conv3x3;
   import img_pkg::*;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = W + 2;
   localparam int PH = H + 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_in;
   logic       rdy_g, vout_g, last_g;
   logic [7:0] dout_g;
   logic       rdy_s, vout_s, last_s;
   logic [7:0] dout_s;

   always #5 clk = ~clk;

   conv3x3 #(.WIDTH(W), .HEIGHT(H), .MODE(0)) u_gauss (
      .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .ready_out(rdy_g), .data_out(dout_g), .valid_out(vout_g),
      .ready_in(ready_in), .last_out(last_g)
   );

   conv3x3 #(.WIDTH(W), .HEIGHT(H), .MODE(1)) u_sobel (
      .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .ready_out(rdy_s), .data_out(dout_s), .valid_out(vout_s),
      .ready_in(ready_in), .last_out(last_s)
   );

   typedef struct {
      logic [7:0] g;
      logic [7:0] s;
      logic       last;
   } exp_t;

   int         checks = 0;
   int         errors = 0;
   int         img [H][W];
   logic [7:0] stream [$];
   exp_t       sb [$];
   logic [7:0] got_g [$];
   logic       got_l [$];
   logic [7:0] golden [16];
   int         mr, mc, n_acc, cyc, gap_pct, bp_mode;
   logic       hold_v, hold_l;
   logic [7:0] hold_g, hold_s;
   logic       bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int pix(input int r, input int c);
      if (r == 0 || c == 0 || r == PH - 1 || c == PW - 1) return 0;
      return img[r-1][c-1];
   endfunction

   function automatic int gauss_ref(input int r, input int c);
      int s;
      s = pix(r-1,c-1) + 2*pix(r-1,c) + pix(r-1,c+1)
        + 2*pix(r,c-1) + 4*pix(r,c)   + 2*pix(r,c+1)
        + pix(r+1,c-1) + 2*pix(r+1,c) + pix(r+1,c+1);
      return s / 16;
   endfunction

   function automatic int sobel_ref(input int r, input int c);
      int gx, gy, m;
      gx = (pix(r-1,c+1) + 2*pix(r,c+1) + pix(r+1,c+1))
         - (pix(r-1,c-1) + 2*pix(r,c-1) + pix(r+1,c-1));
      gy = (pix(r+1,c-1) + 2*pix(r+1,c) + pix(r+1,c+1))
         - (pix(r-1,c-1) + 2*pix(r-1,c) + pix(r-1,c+1));
      m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (m > 255) ? 255 : m;
   endfunction

   task automatic set_image(input int kind);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = (kind == 0) ? (r * W + c + 1) : 100;
   endtask

   task automatic load_frame();
      for (int r = 0; r < PH; r++)
         for (int c = 0; c < PW; c++)
            stream.push_back(8'(pix(r, c)));
   endtask

   // One clock: drive at negedge, check settled outputs, update scoreboard.
   task automatic run_cycle();
      exp_t e;
      logic acc;
      ready_in = (bp_mode != 0) ? bp_pat[cyc % 4] : 1'b1;
      if (stream.size() > 0 && $urandom_range(99) >= 32'(gap_pct)) begin
         valid_in = 1'b1;
         data_in  = stream[0];
      end else begin
         valid_in = 1'b0;
         data_in  = 8'($urandom);
      end
      #1;
      if (hold_v) begin
         chk("hold_data_g", 32'(dout_g), 32'(hold_g));
         chk("hold_data_s", 32'(dout_s), 32'(hold_s));
         chk("hold_last",   32'(last_g), 32'(hold_l));
      end
      if (vout_g && !ready_in) begin
         chk("ready_low_g", 32'(rdy_g), 0);
         chk("ready_low_s", 32'(rdy_s), 0);
      end
      if (vout_g && ready_in) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 32'(vout_g), 0);
         end else begin
            e = sb.pop_front();
            chk("gauss_out", 32'(dout_g), 32'(e.g));
            chk("sobel_out", 32'(dout_s), 32'(e.s));
            chk("sobel_valid", 32'(vout_s), 1);
            chk("last_out", 32'(last_g), 32'(e.last));
            got_g.push_back(dout_g);
            got_l.push_back(last_g);
         end
      end
      hold_v = vout_g && !ready_in;
      hold_g = dout_g;
      hold_s = dout_s;
      hold_l = last_g;
      acc = valid_in && rdy_g;
      if (acc) begin
         void'(stream.pop_front());
         n_acc++;
         if (mr >= 2 && mc >= 2) begin
            e.g    = 8'(gauss_ref(mr - 1, mc - 1));
            e.s    = 8'(sobel_ref(mr - 1, mc - 1));
            e.last = (mr == PH - 1) && (mc == PW - 1);
            sb.push_back(e);
         end
         if (mc == PW - 1) begin
            mc = 0;
            mr = (mr == PH - 1) ? 0 : mr + 1;
         end else begin
            mc++;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_all();
      int budget = 3000;
      while ((stream.size() > 0 || sb.size() > 0 || vout_g) && budget > 0) begin
         run_cycle();
         budget--;
      end
      if (budget == 0) chk("timeout", 0, 1);
   endtask

   task automatic start_test(input int b, input int g);
      bp_mode = b;
      gap_pct = g;
      got_g.delete();
      got_l.delete();
   endtask

   int nl;

   initial begin
      reset    = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      data_in  = 8'd0;
      mr = 0; mc = 0; n_acc = 0; cyc = 0; gap_pct = 0; bp_mode = 0;
      hold_v = 1'b0; hold_l = 1'b0; hold_g = '0; hold_s = '0;
      @(negedge clk);
      #1;
      chk("rst_valid", 32'(vout_g), 0);
      chk("rst_data",  32'(dout_g), 0);
      chk("rst_last",  32'(last_g), 0);
      chk("rst_ready", 32'(rdy_g), 1);
      @(negedge clk);
      reset = 1'b1;

      // Gaussian ramp
      set_image(0);
      start_test(0, 0);
      load_frame();
      run_all();
      chk("ramp_count", 32'(got_g.size()), 16);
      chk("ramp_idx5", 32'(got_g[5]), 6);
      nl = 0;
      foreach (got_l[i]) nl += int'(got_l[i]);
      chk("ramp_last_count", 32'(nl), 1);
      chk("ramp_last_pos", 32'(got_l[15]), 1);
      for (int i = 0; i < 16; i++) golden[i] = 8'(gauss_ref(i / W + 1, i % W + 1));

      // Constant image: both filters
      set_image(1);
      start_test(0, 0);
      load_frame();
      run_all();
      chk("const_count", 32'(got_g.size()), 16);
      chk("const_corner", 32'(got_g[0]), 56);
      chk("const_corner15", 32'(got_g[15]), 56);
      chk("const_edge", 32'(got_g[1]), 75);
      chk("const_edge4", 32'(got_g[4]), 75);
      chk("const_interior", 32'(got_g[5]), 100);
      chk("const_interior10", 32'(got_g[10]), 100);

      // Ramp under backpressure
      set_image(0);
      start_test(1, 0);
      load_frame();
      run_all();
      chk("bp_count", 32'(got_g.size()), 16);
      for (int i = 0; i < 16; i++) chk("bp_vs_golden", 32'(got_g[i]), 32'(golden[i]));

      // Gapped input, reset after 10 padded pixels
      start_test(0, 30);
      load_frame();
      n_acc = 0;
      for (int k = 0; k < 500 && n_acc < 10; k++) run_cycle();
      chk("pre_reset_acc", 32'(n_acc), 10);
      reset = 1'b0;
      valid_in = 1'b0;
      #1;
      chk("reset_valid_g", 32'(vout_g), 0);
      chk("reset_data_g",  32'(dout_g), 0);
      chk("reset_valid_s", 32'(vout_s), 0);
      chk("reset_data_s",  32'(dout_s), 0);
      stream.delete();
      sb.delete();
      mr = 0; mc = 0; hold_v = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      start_test(0, 30);
      load_frame();
      run_all();
      chk("gap_count", 32'(got_g.size()), 16);
      for (int i = 0; i < 16; i++) chk("gap_vs_golden", 32'(got_g[i]), 32'(golden[i]));

      // Back-to-back frames
      start_test(0, 0);
      load_frame();
      load_frame();
      run_all();
      chk("b2b_count", 32'(got_g.size()), 32);
      for (int i = 0; i < 32; i++) chk("b2b_vs_golden", 32'(got_g[i]), 32'(golden[i % 16]));
      chk("b2b_last16", 32'(got_l[15]), 1);
      chk("b2b_last32", 32'(got_l[31]), 1);
      nl = 0;
      foreach (got_l[i]) nl += int'(got_l[i]);
      chk("b2b_last_count", 32'(nl), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
